// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding several write requesters into one FIFO write port
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          wclk,
   input  logic                          w_rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          wen,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
   output logic                          busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;
   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] last_owner;
   logic [IW-1:0] nxt_owner;
   logic [IW-1:0] cand;
   logic          found;
   logic          accept;
   logic          done;
   assign busy      = (state == BURST);
   assign accept    = w_rstn & busy & req_valid[gnt_id] & ~full;
   assign wen       = accept;
   assign req_ready = NUM_REQ'(accept) << gnt_id;
   assign data_in   = busy ? req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign done      = ~req_valid[gnt_id] | (accept & (cnt == CW'(BURST_LEN - 1)));
   // round-robin search starting just after the previous owner, wrapping around
   always_comb begin
      nxt_owner = last_owner;
      cand      = last_owner;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand      = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
         nxt_owner = (!found && req_valid[cand]) ? cand : nxt_owner;
         found     = found | req_valid[cand];
      end
   end
   // grant on IDLE, count accepted words in BURST, release on burst end or owner withdrawal
   always_ff @(posedge wclk or negedge w_rstn) begin
      if (!w_rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         gnt_id     <= '0;
         last_owner <= IW'(NUM_REQ - 1);
      end else if (state == IDLE) begin
         if (|req_valid && !full) begin
            state  <= BURST;
            gnt_id <= nxt_owner;
            cnt    <= '0;
         end
      end else if (done) begin
         state      <= IDLE;
         last_owner <= gnt_id;
      end else if (accept) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios with a per-cycle scoreboard of expected write-port behaviour
module tb_fifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   logic              wclk;
   logic              w_rstn;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              full;
   logic              wen;
   logic [DW-1:0]     data_in;
   logic [1:0]        gnt_id;
   logic              busy;
   typedef struct {
      bit         full;
      bit         wen;
      bit         busy;
      int         id;
      logic [7:0] data;
   } ent_t;
   ent_t sb[$];
   int   rem[NR];
   int   nxt[NR];
   int   cur_id;
   int   n_tests;
   int   n_fail;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(4)) dut (
      .wclk(wclk), .w_rstn(w_rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .full(full), .wen(wen), .data_in(data_in),
      .gnt_id(gnt_id), .busy(busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]        = rem[i] > 0;
         req_data[i*DW +: DW] = (rem[i] > 0) ? 8'(i*16 + nxt[i]) : 8'h00;
      end
   endtask

   function automatic void p_idle(bit f = 1'b0);
      sb.push_back('{f, 1'b0, 1'b0, cur_id, 8'h00});
   endfunction

   function automatic void p_write(int id, int k);
      cur_id = id;
      sb.push_back('{1'b0, 1'b1, 1'b1, id, 8'(id*16 + k)});
   endfunction

   function automatic void p_wait(int id, bit f);
      cur_id = id;
      sb.push_back('{f, 1'b0, 1'b1, id, 8'h00});
   endfunction

   task automatic cycle();
      ent_t       e;
      logic [3:0] rdy;
      e = sb.pop_front();
      full = e.full;
      @(negedge wclk);
      chk("wen", wen, e.wen);
      chk("busy", busy, e.busy);
      chk("gnt_id", gnt_id, e.id);
      chk("no_wen_while_full", wen & full, 0);
      if (e.wen) begin
         chk("data_in", data_in, e.data);
         chk("req_ready", req_ready, 1 << e.id);
      end else chk("req_ready_zero", req_ready, 0);
      if (!e.busy) chk("data_in_idle", data_in, 0);
      rdy = req_ready;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NR; i++) if (rdy[i]) begin
         nxt[i]++;
         rem[i]--;
      end
      drive();
   endtask

   task automatic drain();
      while (sb.size() > 0) cycle();
   endtask

   task automatic do_reset();
      w_rstn = 1'b0;
      full   = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 1;
         nxt[i] = 0;
      end
      drive();
      @(posedge wclk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_wen", wen, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_data_in", data_in, 0);
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      cur_id = 0;
      w_rstn = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      // two requesters with 6 words each, alternating bursts
      do_reset();
      rem[0] = 6;
      rem[2] = 6;
      drive();
      p_idle();
      for (int k = 0; k < 4; k++) p_write(0, k);
      p_idle();
      for (int k = 0; k < 4; k++) p_write(2, k);
      p_idle();
      p_write(0, 4);
      p_write(0, 5);
      p_wait(0, 1'b0);
      p_idle();
      p_write(2, 4);
      p_write(2, 5);
      p_wait(2, 1'b0);
      p_idle();
      drain();
      // all requesters continuously valid: 0,1,2,3,0 with full bursts
      do_reset();
      for (int i = 0; i < NR; i++) rem[i] = 8;
      drive();
      for (int b = 0; b < 5; b++) begin
         p_idle();
         for (int k = 0; k < 4; k++) p_write(b % NR, (b / NR) * 4 + k);
      end
      drain();
      // full stalls requester 1 after its second word
      do_reset();
      rem[1] = 4;
      drive();
      p_idle();
      p_write(1, 0);
      p_write(1, 1);
      for (int k = 0; k < 3; k++) p_wait(1, 1'b1);
      p_write(1, 2);
      p_write(1, 3);
      p_idle();
      drain();
      // requester 3 withdraws after 2 words; next search starts at 0
      do_reset();
      rem[3] = 2;
      drive();
      p_idle();
      p_write(3, 0);
      p_write(3, 1);
      p_wait(3, 1'b0);
      p_idle();
      drain();
      rem[0] = 1;
      rem[3] = 1;
      drive();
      p_idle();
      p_write(0, 0);
      p_wait(0, 1'b0);
      p_idle();
      p_write(3, 2);
      p_wait(3, 1'b0);
      p_idle();
      drain();
      // full held in IDLE blocks the grant
      do_reset();
      rem[3] = 2;
      drive();
      for (int k = 0; k < 3; k++) p_idle(1'b1);
      p_idle(1'b0);
      p_write(3, 0);
      p_write(3, 1);
      p_wait(3, 1'b0);
      p_idle();
      drain();
      // asynchronous reset in the middle of a burst
      do_reset();
      rem[1] = 4;
      drive();
      p_idle();
      p_write(1, 0);
      drain();
      chk("pre_rst_wen", wen, 1);
      #2;
      w_rstn = 1'b0;
      rem[0] = 4;
      drive();
      #1;
      chk("async_rst_wen", wen, 0);
      chk("async_rst_req_ready", req_ready, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_gnt_id", gnt_id, 0);
      @(posedge wclk);
      #1;
      chk("held_rst_wen", wen, 0);
      chk("held_rst_req_ready", req_ready, 0);
      cur_id = 0;
      w_rstn = 1'b1;
      p_idle();
      for (int k = 0; k < 4; k++) p_write(0, k);
      p_idle();
      for (int k = 1; k < 4; k++) p_write(1, k);
      p_wait(1, 1'b0);
      p_idle();
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of each requester data word and of data_in.
REQ-002 Parameter: NUM_REQ, default 4, number of write requesters; legal range 2..8.
REQ-003 Parameter: BURST_LEN, default 4, maximum words accepted per grant; legal range 1..16.
REQ-004 Port: wclk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: w_rstn  input  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  input  NUM_REQ  bit i set = requester i has a word to write.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: req_ready  output  NUM_REQ  one-hot or zero; bit i set = requester i word consumed this cycle.
REQ-009 Port: full  input  1  FIFO write-side full flag.
REQ-010 Port: wen  output  1  FIFO write enable.
REQ-011 Port: data_in  output  DATA_WIDTH  FIFO write data.
REQ-012 Port: gnt_id  output  clog2(NUM_REQ)  index of current burst owner; valid while busy=1.
REQ-013 Port: busy  output  1  high while state is BURST.

Function
REQ-014 FSM states: IDLE, BURST; encoding is implementer's choice.
REQ-015 IDLE -> BURST when any req_valid bit is set and full=0; owner = first set bit searching round-robin from (last_owner+1) mod NUM_REQ upward with wrap.
REQ-016 No word is accepted in the IDLE cycle; first acceptance possible in the first BURST cycle (one-cycle arbitration latency).
REQ-017 In BURST, accept = req_valid[owner] & ~full; combinationally wen = accept, req_ready[owner] = accept, data_in = req_data[owner slice].
REQ-018 wen is zero-latency with respect to full; wen=1 while full=1 is forbidden under all conditions.
REQ-019 When wen=0, data_in is the owner's slice in BURST and all-zero in IDLE; req_ready bits of non-owners are always 0.
REQ-020 Burst counter (width clog2(BURST_LEN+1)) clears on entry to BURST and increments on each accept.
REQ-021 BURST -> IDLE at the edge where accept=1 and counter equals BURST_LEN-1, or where req_valid[owner]=0; last_owner <= owner on exit.
REQ-022 full=1 in BURST: no accept, counter holds, state holds (owner keeps grant until full clears).
REQ-023 Owner withdraws valid in the same cycle full=1: exit to IDLE (withdrawal takes priority).
REQ-024 A requester that loses arbitration keeps req_valid; it is served in at most NUM_REQ-1 subsequent bursts (starvation-free).
REQ-025 gnt_id and busy are registered; gnt_id holds its value after BURST exit until next grant.

Reset
REQ-026 w_rstn=0 asynchronously forces: state=IDLE, counter=0, gnt_id=0, last_owner=NUM_REQ-1 (requester 0 wins first), busy=0.
REQ-027 During reset wen=0 and req_ready=0 regardless of inputs; a burst in progress is abandoned, no partial word written.
REQ-028 Release of w_rstn takes effect at a wclk edge; first grant possible on the first edge after release.

Verification
REQ-029 Reset release, req_valid=4'b0101, full=0, each holds 6 words -> req0 writes 4 words (wen 4 cycles), IDLE 1 cycle, req2 writes 4, IDLE, req0 writes remaining 2, IDLE, req2 writes remaining 2; FIFO order matches.
REQ-030 All 4 requesters continuously valid -> grant order 0,1,2,3,0 with exactly BURST_LEN=4 writes per burst, gnt_id sequence matches.
REQ-031 Owner req1 in BURST, full=1 for 3 cycles after 2nd word -> wen=0 and req_ready=0 those 3 cycles, state BURST, then words 3-4 written; checker asserts never wen&full.
REQ-032 req3 valid for 2 words only, BURST_LEN=4 -> 2 writes, exit on valid drop, last_owner=3, next grant searches from 0.
REQ-033 w_rstn asserted mid-burst after 1st of 4 words -> wen/req_ready drop same cycle (asynchronous), busy=0; after release requester 0 granted first.
REQ-034 full=1 while in IDLE with req_valid=4'b1000 -> stays IDLE, no grant; full falls -> grant req3 next edge, writes begin following cycle.
